// File: rtl/cpu_txn_gen_if.sv
// Valid/ready stream carrying 64-bit {cpu_index, seq} words from cpu_txn_gen
// to the CPU-side DPI client stage.
interface cpu_txn_gen_if;
  logic        data_vld;
  logic        data_rdy;
  logic [63:0] data;

  modport master (output data_vld, output data, input data_rdy);
  modport slave  (input data_vld, input data, output data_rdy);
endinterface

// File: rtl/cpu_txn_gen.sv
// Tagged 64-bit transaction source with LFSR-driven idle gaps and a sticky done flag.
// Optional running XOR of transferred words: define CPU_TXN_GEN_CHECKSUM_EN.
module cpu_txn_gen #(
  parameter int unsigned NUM_TXN   = 1000,
  parameter int unsigned MAX_GAP   = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        cpu_index,
  input  logic               start,
  cpu_txn_gen_if.master      bus,
  output logic               transactions_done,
  output logic [31:0]        txn_count
`ifdef CPU_TXN_GEN_CHECKSUM_EN
  ,
  output logic [63:0]        checksum
`endif
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [31:0] NUM_TXN_L = 32'(NUM_TXN);
  localparam logic [15:0] GAP_MOD   = 16'(MAX_GAP + 1);

  state_t      state_reg, state_next;
  logic        vld_reg, vld_next;
  logic [63:0] data_reg, data_next;
  logic        done_reg, done_next;
  logic [31:0] count_reg, count_next;
  logic [31:0] seq_reg, seq_next;
  logic [31:0] cpu_q_reg, cpu_q_next;
  logic [15:0] lfsr_reg, lfsr_next;
  logic [15:0] gap_reg, gap_next;

  logic        xfer;
  logic [31:0] seq_plus;
  logic [15:0] lfsr_adv;
  logic [15:0] gap_val;

  assign xfer     = vld_reg && bus.data_rdy;
  assign seq_plus = seq_reg + 32'd1;
  // Right-shifting Fibonacci form of taps 16,14,13,11.
  assign lfsr_adv = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};

  if (MAX_GAP == 0) begin : g_no_gap
    assign gap_val = 16'd0;
  end else begin : g_gap
    assign gap_val = lfsr_adv % GAP_MOD;
  end

  always_comb begin
    state_next = state_reg;
    vld_next   = vld_reg;
    data_next  = data_reg;
    done_next  = done_reg;
    count_next = count_reg;
    seq_next   = seq_reg;
    cpu_q_next = cpu_q_reg;
    lfsr_next  = lfsr_reg;
    gap_next   = gap_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          cpu_q_next = cpu_index;
          seq_next   = 32'd0;
          if (NUM_TXN_L == 32'd0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = SEND;
            vld_next   = 1'b1;
            data_next  = {cpu_index, 32'd0};
          end
        end
      end
      SEND: begin
        if (xfer) begin
          count_next = count_reg + 32'd1;
          seq_next   = seq_plus;
          if (seq_plus == NUM_TXN_L) begin
            vld_next   = 1'b0;
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            lfsr_next = lfsr_adv;
            if (gap_val == 16'd0) begin
              data_next = {cpu_q_reg, seq_plus};
            end else begin
              vld_next   = 1'b0;
              gap_next   = gap_val;
              state_next = GAP;
            end
          end
        end
      end
      GAP: begin
        // seq_reg already points at the next word after the transfer.
        if (gap_reg <= 16'd1) begin
          gap_next   = 16'd0;
          vld_next   = 1'b1;
          data_next  = {cpu_q_reg, seq_reg};
          state_next = SEND;
        end else begin
          gap_next = gap_reg - 16'd1;
        end
      end
      default: begin
        vld_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      vld_reg   <= 1'b0;
      data_reg  <= 64'd0;
      done_reg  <= 1'b0;
      count_reg <= 32'd0;
      seq_reg   <= 32'd0;
      cpu_q_reg <= 32'd0;
      lfsr_reg  <= LFSR_SEED;
      gap_reg   <= 16'd0;
    end else begin
      state_reg <= state_next;
      vld_reg   <= vld_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      count_reg <= count_next;
      seq_reg   <= seq_next;
      cpu_q_reg <= cpu_q_next;
      lfsr_reg  <= lfsr_next;
      gap_reg   <= gap_next;
    end
  end

`ifdef CPU_TXN_GEN_CHECKSUM_EN
  logic [63:0] checksum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_reg <= 64'd0;
    end else if (xfer && !done_reg) begin
      checksum_reg <= checksum_reg ^ data_reg;
    end
  end

  assign checksum = checksum_reg;
`endif

  assign bus.data_vld      = vld_reg;
  assign bus.data          = data_reg;
  assign transactions_done = done_reg;
  assign txn_count         = count_reg;

endmodule

// File: tb/tb_cpu_txn_gen.sv
// Directed bench for cpu_txn_gen: three instances cover back-to-back, random-gap
// and zero-length configurations.
module tb_cpu_txn_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpu_index = 32'd0;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic        done_a, done_b, done_c;
  logic [31:0] cnt_a, cnt_b, cnt_c;
`ifdef CPU_TXN_GEN_CHECKSUM_EN
  logic [63:0] cs_a, cs_b, cs_c;
`endif

  int checks = 0;
  int errors = 0;

  cpu_txn_gen_if bus_a ();
  cpu_txn_gen_if bus_b ();
  cpu_txn_gen_if bus_c ();

  always #5 clk = ~clk;

  cpu_txn_gen #(.NUM_TXN(4), .MAX_GAP(0), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .rst_n(rst_n), .cpu_index(cpu_index), .start(start_a),
    .bus(bus_a.master), .transactions_done(done_a), .txn_count(cnt_a)
`ifdef CPU_TXN_GEN_CHECKSUM_EN
    , .checksum(cs_a)
`endif
  );

  cpu_txn_gen #(.NUM_TXN(50), .MAX_GAP(3), .LFSR_SEED(16'hACE1)) dut_b (
    .clk(clk), .rst_n(rst_n), .cpu_index(cpu_index), .start(start_b),
    .bus(bus_b.master), .transactions_done(done_b), .txn_count(cnt_b)
`ifdef CPU_TXN_GEN_CHECKSUM_EN
    , .checksum(cs_b)
`endif
  );

  cpu_txn_gen #(.NUM_TXN(0), .MAX_GAP(3), .LFSR_SEED(16'hACE1)) dut_c (
    .clk(clk), .rst_n(rst_n), .cpu_index(cpu_index), .start(start_c),
    .bus(bus_c.master), .transactions_done(done_c), .txn_count(cnt_c)
`ifdef CPU_TXN_GEN_CHECKSUM_EN
    , .checksum(cs_c)
`endif
  );

  typedef struct {
    logic        vld;
    logic        chk_data;
    logic [63:0] data;
    logic        done;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst_n     = 1'b0;
    start_a   = 1'b0;
    start_b   = 1'b0;
    start_c   = 1'b0;
    bus_a.data_rdy = 1'b1;
    bus_b.data_rdy = 1'b1;
    bus_c.data_rdy = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference gap LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting right.
  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return (s >> 1) | (16'(b) << 15);
  endfunction

  initial begin
    int words, idle, cyc, exp_gap;
    logic [15:0] lfsr_m;
    logic pulsed_send, pulsed_gap, seen_vld;

    tbl[0] = '{1'b1, 1'b1, 64'h00000003_00000000, 1'b0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 64'h00000003_00000001, 1'b0, 32'd1};
    tbl[2] = '{1'b1, 1'b1, 64'h00000003_00000002, 1'b0, 32'd2};
    tbl[3] = '{1'b1, 1'b1, 64'h00000003_00000003, 1'b0, 32'd3};
    tbl[4] = '{1'b0, 1'b0, 64'd0,                 1'b1, 32'd4};
    tbl[5] = '{1'b0, 1'b0, 64'd0,                 1'b1, 32'd4};

    reset_all();

    check("rst_vld_a", 64'(bus_a.data_vld), 64'd0);
    check("rst_data_a", bus_a.data, 64'd0);
    check("rst_done_a", 64'(done_a), 64'd0);
    check("rst_cnt_a", 64'(cnt_a), 64'd0);
    check("rst_vld_b", 64'(bus_b.data_vld), 64'd0);
    check("rst_done_c", 64'(done_c), 64'd0);
`ifdef CPU_TXN_GEN_CHECKSUM_EN
    check("rst_cs_a", cs_a, 64'd0);
`endif

    // Test 1: back-to-back, table driven
    cpu_index = 32'd3;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_vld_c%0d", i + 1), 64'(bus_a.data_vld), 64'(tbl[i].vld));
      if (tbl[i].chk_data)
        check($sformatf("t1_data_c%0d", i + 1), bus_a.data, tbl[i].data);
      check($sformatf("t1_done_c%0d", i + 1), 64'(done_a), 64'(tbl[i].done));
      check($sformatf("t1_cnt_c%0d", i + 1), 64'(cnt_a), 64'(tbl[i].cnt));
      $display("t1 cycle %0d: vld=%0b data=%h done=%0b cnt=%0d",
               i + 1, bus_a.data_vld, bus_a.data, done_a, cnt_a);
      tick();
    end
`ifdef CPU_TXN_GEN_CHECKSUM_EN
    check("t1_checksum", cs_a, 64'd0);
`endif

    // Test 2: backpressure while seq=2 is presented
    reset_all();
    cpu_index = 32'd3;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    check("t2_pre_data", bus_a.data, 64'h00000003_00000002);
    bus_a.data_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t2_hold_vld_%0d", i), 64'(bus_a.data_vld), 64'd1);
      check($sformatf("t2_hold_data_%0d", i), bus_a.data, 64'h00000003_00000002);
      check($sformatf("t2_hold_cnt_%0d", i), 64'(cnt_a), 64'd2);
      $display("t2 stall %0d: data=%h cnt=%0d", i, bus_a.data, cnt_a);
    end
    bus_a.data_rdy = 1'b1;
    tick();
    check("t2_next_data", bus_a.data, 64'h00000003_00000003);
    check("t2_next_cnt", 64'(cnt_a), 64'd3);
`ifdef CPU_TXN_GEN_CHECKSUM_EN
    check("t2_checksum", cs_a, 64'h00000003_00000003);
`endif

    // Test 3 + 6: random gaps vs. reference LFSR, with stray start pulses
    reset_all();
    cpu_index = 32'd5;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cpu_index = 32'd9;
    words = 0; idle = 0; cyc = 0; exp_gap = 0;
    lfsr_m = 16'hACE1;
    pulsed_send = 1'b0; pulsed_gap = 1'b0;
    while (words < 50 && cyc < 400) begin
      start_b = 1'b0;
      if (bus_b.data_vld) begin
        check($sformatf("t3_data_%0d", words), bus_b.data, {32'd5, 32'(words)});
        if (words > 0) begin
          check($sformatf("t3_gap_%0d", words), 64'(idle), 64'(exp_gap));
          check($sformatf("t3_gap_range_%0d", words), 64'(idle <= 3), 64'd1);
        end
        $display("t3 word %0d: data=%h idle_before=%0d", words, bus_b.data, idle);
        if (words < 49) begin
          lfsr_m = model_step(lfsr_m);
          exp_gap = int'(lfsr_m % 16'd4);
        end
        if (words == 3 && !pulsed_send) begin
          start_b = 1'b1;
          pulsed_send = 1'b1;
        end
        idle = 0;
        words++;
      end else if (words > 0) begin
        idle++;
        if (!pulsed_gap) begin
          start_b = 1'b1;
          pulsed_gap = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    start_b = 1'b0;
    check("t3_words", 64'(words), 64'd50);
    check("t3_done", 64'(done_b), 64'd1);
    check("t3_cnt", 64'(cnt_b), 64'd50);
    check("t3_vld_after", 64'(bus_b.data_vld), 64'd0);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    tick();
    check("t6_done_hold", 64'(done_b), 64'd1);
    check("t6_cnt_hold", 64'(cnt_b), 64'd50);
    check("t6_vld_hold", 64'(bus_b.data_vld), 64'd0);

    // Test 4: zero-length run
    reset_all();
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check("t4_done", 64'(done_c), 64'd1);
    check("t4_cnt", 64'(cnt_c), 64'd0);
    seen_vld = bus_c.data_vld;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_vld = seen_vld | bus_c.data_vld;
    end
    check("t4_never_vld", 64'(seen_vld), 64'd0);
    check("t4_done_sticky", 64'(done_c), 64'd1);
    $display("t4: done=%0b cnt=%0d", done_c, cnt_c);

    // Test 5: asynchronous reset mid-stream, then restart
    reset_all();
    cpu_index = 32'd3;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    check("t5_pre_cnt", 64'(cnt_a), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_vld", 64'(bus_a.data_vld), 64'd0);
    check("t5_async_data", bus_a.data, 64'd0);
    check("t5_async_cnt", 64'(cnt_a), 64'd0);
    check("t5_async_done", 64'(done_a), 64'd0);
    tick();
    rst_n = 1'b1;
    cpu_index = 32'd7;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t5_restart_vld", 64'(bus_a.data_vld), 64'd1);
    check("t5_restart_data", bus_a.data, 64'h00000007_00000000);
    $display("t5: restart data=%h", bus_a.data);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
